// File: rtl/bit_serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding
// and carry helper. Imported by the RTL and the bench.
package bit_serial_adder_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   // Majority of three: the carry out of a full-adder cell
   function automatic logic maj(
      input logic x,
      input logic y,
      input logic z
   );
      return (x & y) | (x & z) | (y & z);
   endfunction

endpackage

// File: rtl/bit_serial_adder_fa.sv
// Single-bit full adder cell in data-flow form.
// Purely combinational; sequencing lives in bit_serial_adder.
module fa_bit
   import bit_serial_adder_pkg::*;
(
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = x ^ y ^ ci;
   assign co = maj(x, y, ci);

endmodule

// File: rtl/bit_serial_adder.sv
// Multi-cycle LSB-first bit-serial adder, one result bit per clock.
// Optional SERIAL_ADD_OVF_EN adds a registered two's-complement ovf output.
module bit_serial_adder
   import bit_serial_adder_pkg::*;
#(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
   output logic             ovf,
`endif
   output logic             cout
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int SW = (WIDTH > 1) ? WIDTH - 1 : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   state_t           state_n;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [SW-1:0]    s_sh;
   logic [CW-1:0]    cnt;
   logic             c;
   logic             s;
   logic             co;
   logic             last;
   logic [WIDTH-1:0] s_next;

   fa_bit u_fa (
      .x  (a_sh[0]),
      .y  (b_sh[0]),
      .ci (c),
      .s  (s),
      .co (co)
   );

   // Partial sum with the new bit shifted in at the MSB
   generate
      if (WIDTH == 1) begin : g_w1
         assign s_next = s;
      end else begin : g_wn
         assign s_next = {s, s_sh};
      end
   endgenerate

   assign last = (cnt == LAST);
   assign busy = (state == S_SHIFT);
   assign done = (state == S_DONE);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next-state logic; start is only honoured in IDLE
   always_comb begin
      state_n = state;
      unique case (state)
         S_IDLE:  if (start) state_n = S_SHIFT;
         S_SHIFT: if (last)  state_n = S_DONE;
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   // Operand capture, per-bit shifting, result and carry registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh <= '0;
         b_sh <= '0;
         s_sh <= '0;
         cnt  <= '0;
         c    <= 1'b0;
         sum  <= '0;
         cout <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
         ovf  <= 1'b0;
`endif
      end else begin
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  a_sh <= a;
                  b_sh <= b;
                  c    <= cin;
                  cnt  <= '0;
               end
            end
            S_SHIFT: begin
               a_sh <= a_sh >> 1;
               b_sh <= b_sh >> 1;
               c    <= co;
               s_sh <= s_next[WIDTH-1:WIDTH-SW];
               cnt  <= cnt + CW'(1);
               if (last) begin
                  sum  <= s_next;
                  cout <= co;
`ifdef SERIAL_ADD_OVF_EN
                  // c is the carry into the MSB cell here
                  ovf  <= c ^ co;
`endif
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder (WIDTH=3) against an
// arithmetic reference model; ovf checks when SERIAL_ADD_OVF_EN is set.
module tb_bit_serial_adder;
   import bit_serial_adder_pkg::*;

   localparam int W = 3;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
`ifdef SERIAL_ADD_OVF_EN
   logic         ovf;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   bit_serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
`ifdef SERIAL_ADD_OVF_EN
      .ovf   (ovf),
`endif
      .cout  (cout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // {cout,sum} as plain unsigned arithmetic
   function automatic int ref_add(input int x, input int y, input int ci);
      return (x + y + ci) % (1 << (W + 1));
   endfunction

   // Signed overflow: true result outside the W-bit two's-complement range
   function automatic int ref_ovf(input int x, input int y, input int ci);
      int sx, sy, r;
      sx = (x >= (1 << (W - 1))) ? x - (1 << W) : x;
      sy = (y >= (1 << (W - 1))) ? y - (1 << W) : y;
      r  = sx + sy + ci;
      return (r > (1 << (W - 1)) - 1 || r < -(1 << (W - 1))) ? 1 : 0;
   endfunction

   task automatic drive_start(input int x, input int y, input int ci);
      @(negedge clk);
      a = W'(x);
      b = W'(y);
      cin = ci[0];
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      cin = 1'($urandom);
   endtask

   // Full operation; counts busy/done over a bounded window
   task automatic run_op(input int x, input int y, input int ci);
      int nb, nd, exp;
      logic [W-1:0] gs;
      logic gc;
`ifdef SERIAL_ADD_OVF_EN
      logic go;
      go = 1'b0;
`endif
      nb = 0;
      nd = 0;
      gs = '0;
      gc = 1'b0;
      exp = ref_add(x, y, ci);
      drive_start(x, y, ci);
      for (int n = 0; n < W + 4; n++) begin
         if (n > 0) @(negedge clk);
         if (busy) nb++;
         if (done) begin
            nd++;
            gs = sum;
            gc = cout;
`ifdef SERIAL_ADD_OVF_EN
            go = ovf;
`endif
         end
      end
      check("busy_len", 32'(nb), 32'(W));
      check("done_cnt", 32'(nd), 32'd1);
      check("sum", 32'(gs), 32'(exp % (1 << W)));
      check("cout", 32'(gc), 32'(exp >> W));
      check("sum_held", 32'(sum), 32'(exp % (1 << W)));
`ifdef SERIAL_ADD_OVF_EN
      check("ovf", 32'(go), 32'(ref_ovf(x, y, ci)));
`endif
   endtask

   initial begin
      int nd, nb;
      logic [W-1:0] gs;
      logic gc;

      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_cout", 32'(cout), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      run_op(3, 3, 0);
      run_op(7, 7, 1);
      run_op(0, 0, 0);
      run_op(3, 1, 0);
      run_op(6, 7, 0);

      // Start re-pulsed while busy must be ignored
      drive_start(1, 1, 0);
      a = 3'd7;
      b = 3'd7;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      nd = 0;
      gs = '0;
      gc = 1'b0;
      for (int n = 0; n < 8; n++) begin
         if (done) begin
            nd++;
            gs = sum;
            gc = cout;
         end
         @(negedge clk);
      end
      check("ign_done", 32'(nd), 32'd1);
      check("ign_sum", 32'(gs), 32'd2);
      check("ign_cout", 32'(gc), 32'd0);

      // Reset in the 2nd busy cycle discards the operation
      drive_start(5, 2, 0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_busy", 32'(busy), 32'd0);
      check("mid_done", 32'(done), 32'd0);
      check("mid_sum", 32'(sum), 32'd0);
      check("mid_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
      check("mid_ovf", 32'(ovf), 32'd0);
`endif
      @(negedge clk);
      rst = 1'b0;
      nd = 0;
      nb = 0;
      for (int n = 0; n < 6; n++) begin
         @(negedge clk);
         if (done) nd++;
         if (busy) nb++;
      end
      check("mid_nodone", 32'(nd), 32'd0);
      check("mid_idle", 32'(nb), 32'd0);
      run_op(2, 1, 0);

      // Back-to-back: new start in the IDLE cycle after done
      drive_start(2, 3, 0);
      nd = 0;
      for (int n = 0; n < 10 && nd == 0; n++) begin
         if (done) nd++;
         else @(negedge clk);
      end
      check("b2b_first", 32'(nd), 32'd1);
      check("b2b_sum1", 32'(sum), 32'd5);
      drive_start(6, 5, 0);
      check("b2b_busy", 32'(busy), 32'd1);
      check("b2b_hold", 32'(sum), 32'd5);
      nd = 0;
      for (int n = 0; n < 10 && nd == 0; n++) begin
         if (done) nd++;
         else begin
            if (n == 1) check("b2b_hold2", 32'(sum), 32'd5);
            @(negedge clk);
         end
      end
      check("b2b_second", 32'(nd), 32'd1);
      check("b2b_sum2", 32'(sum), 32'd3);
      check("b2b_cout2", 32'(cout), 32'd1);
      @(negedge clk);

      // Random operations
      for (int i = 0; i < 40; i++) begin
         run_op(int'($urandom_range(7, 0)), int'($urandom_range(7, 0)),
                int'($urandom_range(1, 0)));
      end

      // Exhaustive sweep of every a/b/cin combination
      for (int x = 0; x < (1 << W); x++) begin
         for (int y = 0; y < (1 << W); y++) begin
            for (int ci = 0; ci < 2; ci++) begin
               run_op(x, y, ci);
            end
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
